// File: rtl/pipelined_rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rca_pkg
// Description : Shared constants and helpers for the pipelined ripple-carry
//               adder: default operand/segment widths, the pipeline depth
//               derivation and the legality check for a WIDTH/SEG split.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_rca_pkg;

    localparam int c_DEFAULT_WIDTH = 64;
    localparam int c_DEFAULT_SEG   = 16;

    // Number of ripple segments (and therefore register stages).
    function automatic int numSegments(input int width, input int seg);
        return width / seg;
    endfunction

    // A split is legal when it yields at least one whole segment and no
    // partial segment at the top.
    function automatic bit validSplit(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage : pipelined_rca_pkg
`default_nettype wire

// File: rtl/pipelined_rca_seg.sv
`default_nettype none
// ============================================================================
// Module      : rca_seg
// Description : Combinational SEG-bit ripple-carry adder segment.
// Ports       : s    - SEG-bit sum
//               cOut - carry out of the segment MSB
//               cMsb - carry into the segment MSB (for overflow detection)
//               cIn  - carry into bit 0
//               a, b - SEG-bit operands
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seg
    import pipelined_rca_pkg::*;
#(
    parameter int SEG = c_DEFAULT_SEG
) (
    output logic [SEG-1:0] s,
    output logic           cOut,
    output logic           cMsb,
    input  logic           cIn,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b
);

    // w_carry[i] is the carry into bit i.
    logic [SEG:0] w_carry;

    assign w_carry[0] = cIn;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cOut = w_carry[SEG];
    assign cMsb = w_carry[SEG-1];

endmodule : rca_seg
`default_nettype wire

// File: rtl/pipelined_rca.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rca
// Description : WIDTH-bit add/subtract split into NSEG = WIDTH/SEG ripple
//               segments with one register stage per segment. Stage k adds
//               segment k using the registered carry of stage k-1, forwarding
//               the lower sum bits and the still-unprocessed operand bits
//               (triangular skew). Valid/ready handshake on both sides with a
//               single global advance signal.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid / in_ready - operand beat handshake
//               a, b, cIn, sub      - operands, carry in, subtract select
//               out_valid/out_ready - result handshake
//               s, cOut, ovf, zero  - result, raw carry, signed overflow, s==0
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int SEG   = c_DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cOut,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG = numSegments(WIDTH, SEG);

    if (!validSplit(WIDTH, SEG)) begin : g_badSplit
        $error("pipelined_rca: WIDTH must be a positive multiple of SEG");
    end

    logic             w_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_bEff;
    logic             w_cEff;

    // The whole pipeline moves as one; it only freezes when the output
    // register holds a result the consumer has not taken.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid && w_adv;

    // Subtraction is a + ~b + 1, so cIn is ignored in that mode.
    assign w_bEff = sub ? ~b : b;
    assign w_cEff = sub | cIn;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int OP_W  = WIDTH - k * SEG;   // operand bits not yet added
        localparam int SUM_W = (k + 1) * SEG;     // sum bits known after stage

        logic [OP_W-1:0]  w_opA;
        logic [OP_W-1:0]  w_opB;
        logic             w_cin;
        logic             w_vIn;
        logic [SEG-1:0]   w_segS;
        logic             w_segCout;
        logic             w_segCmsb;
        logic [SUM_W-1:0] w_sumNext;

        logic             r_valid;
        logic [SUM_W-1:0] r_sum;
        logic             r_carry;

        if (k == 0) begin : g_head
            assign w_opA     = a;
            assign w_opB     = w_bEff;
            assign w_cin     = w_cEff;
            assign w_vIn     = w_accept;
            assign w_sumNext = w_segS;
        end else begin : g_body
            assign w_opA     = g_stage[k-1].g_ops.r_aHi;
            assign w_opB     = g_stage[k-1].g_ops.r_bHi;
            assign w_cin     = g_stage[k-1].r_carry;
            assign w_vIn     = g_stage[k-1].r_valid;
            assign w_sumNext = {w_segS, g_stage[k-1].r_sum};
        end

        rca_seg #(
            .SEG (SEG)
        ) u_seg (
            .s    (w_segS),
            .cOut (w_segCout),
            .cMsb (w_segCmsb),
            .cIn  (w_cin),
            .a    (w_opA[SEG-1:0]),
            .b    (w_opB[SEG-1:0])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_vIn;
                r_sum   <= w_sumNext;
                r_carry <= w_segCout;
            end
        end

        if (k < NSEG - 1) begin : g_ops
            // Upper operand segments travel alongside until their stage.
            logic [OP_W-SEG-1:0] r_aHi;
            logic [OP_W-SEG-1:0] r_bHi;
            logic                w_unusedCmsb;

            // Only the top segment needs the carry into its MSB.
            assign w_unusedCmsb = w_segCmsb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_aHi <= '0;
                    r_bHi <= '0;
                end else if (w_adv) begin
                    r_aHi <= w_opA[OP_W-1:SEG];
                    r_bHi <= w_opB[OP_W-1:SEG];
                end
            end
        end else begin : g_tail
            logic r_ovf;

            // Signed overflow: carry into the MSB differs from carry out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_segCout ^ w_segCmsb;
                end
            end

            assign out_valid = r_valid;
            assign s         = r_sum;
            assign cOut      = r_carry;
            assign ovf       = r_ovf;
            assign zero      = (r_sum == '0);
        end
    end

endmodule : pipelined_rca
`default_nettype wire
